// File: rtl/layer_compositor.sv
// layer_compositor: two-stage priority layer select with frame-latched enables and state-change blanking.
// Optional focus-window darkening of selected layers is enabled by defining LAYER_COMPOSITOR_DARK_EN.
module layer_compositor #(
    parameter int NUM_LAYERS   = 6,
    parameter int ADDR_W       = 17,
    parameter int BLANK_FRAMES = 2,
    parameter int ID_W         = 3
`ifdef LAYER_COMPOSITOR_DARK_EN
    ,
    parameter logic [NUM_LAYERS-1:0] DARK_MASK = ~NUM_LAYERS'(1),
    parameter int                    DARK_R    = 48
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
`ifdef LAYER_COMPOSITOR_DARK_EN
    input  logic                         dark,
    input  logic [9:0]                   focus_x,
    input  logic [9:0]                   focus_y,
`endif
    input  logic [9:0]                   h_cnt,
    input  logic [9:0]                   v_cnt,
    input  logic [3:0]                   state,
    input  logic [NUM_LAYERS-1:0]        layer_en,
    input  logic [NUM_LAYERS-1:0]        layer_hit,
    input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
    output logic [ADDR_W-1:0]            pixel_addr,
    output logic                         not_blank,
    output logic [ID_W-1:0]              layer_id,
    output logic                         blanking
);
    localparam int CW = BLANK_FRAMES > 0 ? $clog2(BLANK_FRAMES + 1) : 1;

    logic                         frame_start;
    logic [NUM_LAYERS-1:0]        mask_sel, keep, mask_q, hit1;
    logic [NUM_LAYERS*ADDR_W-1:0] addr1;
    logic [3:0]                   state_q;
    logic [CW-1:0]                blank_cnt;
    logic [ID_W-1:0]              win_id;
    logic [ADDR_W-1:0]            win_addr;
    logic                         win_hit, show;

    assign frame_start = h_cnt == 10'd0 && v_cnt == 10'd0;
    assign mask_sel    = frame_start ? layer_en : mask_q;

`ifdef LAYER_COMPOSITOR_DARK_EN
    logic [10:0] dx, dy, ax, ay;
    logic        far;
    assign dx   = {1'b0, h_cnt} - {1'b0, focus_x};
    assign dy   = {1'b0, v_cnt} - {1'b0, focus_y};
    assign ax   = dx[10] ? -dx : dx;
    assign ay   = dy[10] ? -dy : dy;
    assign far  = ax > 11'(DARK_R) || ay > 11'(DARK_R);
    assign keep = (dark && far) ? ~DARK_MASK : '1;
`else
    assign keep = '1;
`endif

    // Scan from lowest priority upward so the lowest-index hit overwrites last.
    always_comb begin
        win_id   = '0;
        win_addr = '0;
        win_hit  = 1'b0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (hit1[i]) begin
                win_id   = ID_W'(i);
                win_addr = addr1[i*ADDR_W +: ADDR_W];
                win_hit  = 1'b1;
            end
        end
    end

    assign show = win_hit && blank_cnt == '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit1       <= '0;
            addr1      <= '0;
            mask_q     <= '0;
            state_q    <= '0;
            blank_cnt  <= '0;
            pixel_addr <= '0;
            not_blank  <= 1'b0;
            layer_id   <= '0;
            blanking   <= 1'b0;
        end else begin
            hit1  <= layer_hit & mask_sel & keep;
            addr1 <= layer_addr;
            if (frame_start) begin
                mask_q  <= layer_en;
                state_q <= state;
                if (state != state_q && BLANK_FRAMES != 0)
                    blank_cnt <= CW'(BLANK_FRAMES);
                else if (blank_cnt != '0)
                    blank_cnt <= blank_cnt - 1'b1;
            end
            pixel_addr <= show ? win_addr : '0;
            not_blank  <= show;
            layer_id   <= win_id;
            blanking   <= blank_cnt != '0;
        end
    end
endmodule
